// File: rtl/ap_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : ap_seq_pkg
// Purpose  : Shared types and constants for the ap_ctrl start/done sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ap_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    localparam int c_txn_w_default    = 16;
    localparam int c_lat_w_default    = 32;
    localparam int c_max_inflight_lim = 8;

    // Keeps the outstanding-transaction window inside the supported range.
    function automatic int clamp_inflight(input int n);
        if (n < 1) begin
            return 1;
        end
        if (n > c_max_inflight_lim) begin
            return c_max_inflight_lim;
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ap_seq_ts_fifo.sv
//------------------------------------------------------------------------------
// Module   : ap_seq_ts_fifo
// Purpose  : Start-timestamp FIFO; flags entries whose age has reached a full
//            wrap of the cycle counter so latency can saturate.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ap_seq_ts_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic [WIDTH-1:0] now,
    output logic [WIDTH-1:0] head_data,
    output logic             head_aged
);

    localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_aged;
    logic [DEPTH-1:0]   w_wrap;
    logic [c_ptr_w-1:0] r_wr;
    logic [c_ptr_w-1:0] r_rd;

    // The counter revisits a stored timestamp only after 2^WIDTH cycles.
    for (genvar i = 0; i < DEPTH; i++) begin : g_wrap
        assign w_wrap[i] = r_valid[i] & (r_mem[i] == now);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid <= '0;
            r_aged  <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            r_aged <= r_aged | w_wrap;
            if (pop) begin
                r_valid[r_rd] <= 1'b0;
                r_aged[r_rd]  <= 1'b0;
                r_rd          <= (r_rd == c_last) ? '0 : r_rd + 1'b1;
            end
            if (push) begin
                r_mem[r_wr]   <= push_data;
                r_valid[r_wr] <= 1'b1;
                r_aged[r_wr]  <= 1'b0;
                r_wr          <= (r_wr == c_last) ? '0 : r_wr + 1'b1;
            end
        end
    end

    assign head_data = r_mem[r_rd];
    assign head_aged = r_aged[r_rd];

endmodule

`default_nettype wire

// File: rtl/ap_ctrl_sequencer.sv
//------------------------------------------------------------------------------
// Module   : ap_ctrl_sequencer
// Purpose  : Issues N ap_ctrl start/done transactions to a kernel with a bounded
//            inflight window; optional latency statistics when
//            AP_SEQ_LATENCY_STATS_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ap_ctrl_sequencer
    import ap_seq_pkg::*;
#(
    parameter int TXN_W        = c_txn_w_default,
    parameter int MAX_INFLIGHT = 2,
    parameter int LAT_W        = c_lat_w_default
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [TXN_W-1:0] cfg_num_txn,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    output logic             busy,
    output logic             finish,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic [TXN_W-1:0] txn_issued,
    output logic [TXN_W-1:0] txn_done,
    output logic             proto_err,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max
);

    localparam int               c_max_inf = clamp_inflight(MAX_INFLIGHT);
    localparam logic [TXN_W-1:0] c_max     = TXN_W'(c_max_inf);

    seq_state_t       r_state;
    logic [TXN_W-1:0] r_num;
    logic [TXN_W-1:0] r_issued;
    logic [TXN_W-1:0] r_done;
    logic             r_start;
    logic             r_cont;
    logic             r_busy;
    logic             r_finish;
    logic             r_err;

    logic [TXN_W-1:0] w_inflight;
    logic [TXN_W-1:0] w_issued_n;
    logic [TXN_W-1:0] w_done_n;
    logic [TXN_W-1:0] w_inflight_n;
    logic             w_hs;
    logic             w_done_ok;
    logic             w_err_evt;
    logic             w_accept;

    assign w_inflight   = r_issued - r_done;
    assign w_hs         = r_start & ap_ready;
    // A done with nothing outstanding is a protocol error and is never counted.
    assign w_done_ok    = ap_done & r_cont & (w_inflight != '0);
    assign w_err_evt    = (ap_done & (w_inflight == '0)) | (ap_ready & ~r_start);
    assign w_accept     = (r_state == ST_IDLE) & cmd_start;
    assign w_issued_n   = r_issued + TXN_W'(w_hs);
    assign w_done_n     = r_done + TXN_W'(w_done_ok);
    assign w_inflight_n = w_issued_n - w_done_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_num    <= '0;
            r_issued <= '0;
            r_done   <= '0;
            r_start  <= 1'b0;
            r_cont   <= 1'b0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            r_err    <= (r_err & ~w_accept) | w_err_evt;
            r_issued <= w_issued_n;
            r_done   <= w_done_n;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        r_num    <= cfg_num_txn;
                        r_issued <= '0;
                        r_done   <= '0;
                        r_busy   <= 1'b1;
                        if (cfg_num_txn != '0) begin
                            r_state <= ST_ISSUE;
                            r_cont  <= 1'b1;
                            r_start <= 1'b1;
                        end else begin
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_ISSUE: begin
                    // A raised start is held until the kernel takes it.
                    if (r_start && !ap_ready) begin
                        r_start <= 1'b1;
                    end else if ((w_issued_n == r_num) || cmd_abort) begin
                        r_state <= ST_DRAIN;
                        r_start <= 1'b0;
                    end else begin
                        r_start <= (w_inflight_n < c_max);
                    end
                end
                ST_DRAIN: begin
                    if (w_done_n == r_issued) begin
                        r_state <= ST_FINISH;
                        r_cont  <= 1'b0;
                    end
                end
                ST_FINISH: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_finish <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_start <= 1'b0;
                    r_cont  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign finish      = r_finish;
    assign ap_start    = r_start;
    assign ap_continue = r_cont;
    assign txn_issued  = r_issued;
    assign txn_done    = r_done;
    assign proto_err   = r_err;

`ifdef AP_SEQ_LATENCY_STATS_EN
    logic [LAT_W-1:0] r_cycle;
    logic [LAT_W-1:0] r_lat_min;
    logic [LAT_W-1:0] r_lat_max;
    logic [LAT_W-1:0] w_head_ts;
    logic [LAT_W-1:0] w_diff;
    logic [LAT_W-1:0] w_lat;
    logic             w_head_aged;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    ap_seq_ts_fifo #(
        .DEPTH (c_max_inf),
        .WIDTH (LAT_W)
    ) u_ts_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_hs),
        .push_data (r_cycle),
        .pop       (w_done_ok),
        .now       (r_cycle),
        .head_data (w_head_ts),
        .head_aged (w_head_aged)
    );

    // A zero difference means a whole counter wrap has elapsed.
    assign w_diff = r_cycle - w_head_ts;
    assign w_lat  = (w_head_aged || (w_diff == '0)) ? '1 : w_diff;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lat_min <= '0;
            r_lat_max <= '0;
        end else if (w_accept) begin
            r_lat_min <= '1;
            r_lat_max <= '0;
        end else if (w_done_ok) begin
            if (w_lat < r_lat_min) begin
                r_lat_min <= w_lat;
            end
            if (w_lat > r_lat_max) begin
                r_lat_max <= w_lat;
            end
        end
    end

    assign lat_min = r_lat_min;
    assign lat_max = r_lat_max;
`else
    assign lat_min = '0;
    assign lat_max = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ap_ctrl_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_ap_ctrl_sequencer
// Purpose  : Self-checking bench for ap_ctrl_sequencer with an in-order kernel
//            model; AP_SEQ_LATENCY_STATS_EN selects the latency expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ap_ctrl_sequencer;

    localparam int c_maxi = 2;

    logic        clock;
    logic        reset;
    logic [15:0] cfg_num_txn;
    logic        cmd_start;
    logic        cmd_abort;
    logic        busy;
    logic        finish;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_continue;
    logic [15:0] txn_issued;
    logic [15:0] txn_done;
    logic        proto_err;
    logic [31:0] lat_min;
    logic [31:0] lat_max;

    ap_ctrl_sequencer #(
        .TXN_W        (16),
        .MAX_INFLIGHT (c_maxi),
        .LAT_W        (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_num_txn (cfg_num_txn),
        .cmd_start   (cmd_start),
        .cmd_abort   (cmd_abort),
        .busy        (busy),
        .finish      (finish),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .txn_issued  (txn_issued),
        .txn_done    (txn_done),
        .proto_err   (proto_err),
        .lat_min     (lat_min),
        .lat_max     (lat_max)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    // Kernel model: accepts start after ready_delay cycles, completes in order.
    bit kern_en = 1'b0;
    bit k_ready = 1'b0;
    bit k_done  = 1'b0;
    bit m_ready = 1'b0;
    bit m_done  = 1'b0;
    int ready_delay = 0;
    int cur_la = 1;
    int cur_lb = 1;
    int cyc = 0;
    int due_q[$];
    int last_due = 0;
    int k_idx = 0;
    int m_inflight = 0;
    int start_age = 0;
    int inflight_viol = 0;
    int drop_viol = 0;
    int k_d = 0;
    bit prev_start = 1'b0;
    bit prev_hs = 1'b0;
    int fin_cnt = 0;
    int start_hi_cnt = 0;

    assign ap_ready = kern_en ? k_ready : m_ready;
    assign ap_done  = kern_en ? k_done  : m_done;

    always @(negedge clock) begin
        if (!kern_en) begin
            k_ready = 1'b0;
            k_done  = 1'b0;
            due_q.delete();
            last_due = 0;
            k_idx = 0;
            m_inflight = 0;
            start_age = 0;
            prev_start = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if ((ap_start && m_inflight >= c_maxi) || m_inflight > c_maxi) inflight_viol++;
            if (prev_start && !prev_hs && !ap_start) drop_viol++;
            k_ready = ap_start && (start_age >= ready_delay);
            k_done  = (due_q.size() > 0) && (due_q[0] == cyc);
            if (k_done) void'(due_q.pop_front());
            if (k_ready) begin
                k_d = cyc + (((k_idx % 2) == 0) ? cur_la : cur_lb);
                if (k_d <= last_due) k_d = last_due + 1;
                due_q.push_back(k_d);
                last_due = k_d;
                k_idx++;
            end
            m_inflight = m_inflight + int'(k_ready) - int'(k_done);
            start_age = (ap_start && !k_ready) ? start_age + 1 : 0;
            prev_start = ap_start;
            prev_hs = k_ready;
        end
        cyc++;
    end

    always @(negedge clock) begin
        if (finish === 1'b1) fin_cnt++;
        if (ap_start === 1'b1) start_hi_cnt++;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int n;
        int rd;
        int la;
        int lb;
        bit abort;
        int e_iss;
        int e_done;
        int e_min;
        int e_max;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int fin0;
        int iv0;
        int dv0;
        bit got;
        int emin;
        int emax;
        fin0 = fin_cnt;
        iv0 = inflight_viol;
        dv0 = drop_viol;
        ready_delay = v.rd;
        cur_la = v.la;
        cur_lb = v.lb;
        kern_en = 1'b1;
        cfg_num_txn = 16'(v.n);
        cmd_start = 1'b1;
        cmd_abort = v.abort;
        tick();
        cmd_start = 1'b0;
        chk($sformatf("v%0d busy_after_start", idx), 64'(busy), 64'(1));
        chk($sformatf("v%0d proto_err_cleared", idx), 64'(proto_err), 64'(0));
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (finish === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk($sformatf("v%0d finish_seen", idx), 64'(got), 64'(1));
        chk($sformatf("v%0d txn_issued", idx), 64'(txn_issued), 64'(v.e_iss));
        chk($sformatf("v%0d txn_done", idx), 64'(txn_done), 64'(v.e_done));
`ifdef AP_SEQ_LATENCY_STATS_EN
        emin = v.e_min;
        emax = v.e_max;
`else
        emin = 0;
        emax = 0;
`endif
        chk($sformatf("v%0d lat_min", idx), 64'(lat_min), 64'(emin));
        chk($sformatf("v%0d lat_max", idx), 64'(lat_max), 64'(emax));
        tick();
        tick();
        chk($sformatf("v%0d finish_count", idx), 64'(fin_cnt - fin0), 64'(1));
        chk($sformatf("v%0d busy_idle", idx), 64'(busy), 64'(0));
        chk($sformatf("v%0d inflight_limit", idx), 64'(inflight_viol - iv0), 64'(0));
        chk($sformatf("v%0d start_held", idx), 64'(drop_viol - dv0), 64'(0));
        chk($sformatf("v%0d proto_err", idx), 64'(proto_err), 64'(0));
        cmd_abort = 1'b0;
        kern_en = 1'b0;
        tick();
    endtask

    initial begin
        int fin0;
        int sh0;
        bit got;

        //        n  rd la lb ab iss done min max
        vecs[0] = '{4, 0, 3, 3, 1'b0, 4, 4, 3, 3};
        vecs[1] = '{5, 0, 10, 10, 1'b0, 5, 5, 10, 10};
        vecs[2] = '{4, 0, 2, 5, 1'b0, 4, 4, 2, 5};
        vecs[3] = '{3, 2, 1, 1, 1'b0, 3, 3, 1, 1};
        vecs[4] = '{4, 6, 2, 2, 1'b1, 1, 1, 2, 2};
        vecs[5] = '{1, 0, 1, 1, 1'b0, 1, 1, 1, 1};

        reset = 1'b1;
        cfg_num_txn = '0;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        tick();
        tick();
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst finish", 64'(finish), 64'(0));
        chk("rst ap_start", 64'(ap_start), 64'(0));
        chk("rst ap_continue", 64'(ap_continue), 64'(0));
        chk("rst txn_issued", 64'(txn_issued), 64'(0));
        chk("rst txn_done", 64'(txn_done), 64'(0));
        chk("rst proto_err", 64'(proto_err), 64'(0));
        chk("rst lat_min", 64'(lat_min), 64'(0));
        chk("rst lat_max", 64'(lat_max), 64'(0));
        reset = 1'b0;
        tick();

        // Spurious done in IDLE.
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        chk("spurious_done proto_err", 64'(proto_err), 64'(1));
        chk("spurious_done txn_done", 64'(txn_done), 64'(0));
        chk("spurious_done busy", 64'(busy), 64'(0));

        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                // Ready with no start pending also flags an error.
                m_ready = 1'b1;
                tick();
                m_ready = 1'b0;
                tick();
                chk("spurious_ready proto_err", 64'(proto_err), 64'(1));
            end
            run_vec(vecs[i], i);
        end

        // Zero-length run.
        fin0 = fin_cnt;
        sh0 = start_hi_cnt;
        cfg_num_txn = 16'd0;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        chk("zero busy", 64'(busy), 64'(1));
        chk("zero finish_early", 64'(finish), 64'(0));
        tick();
        chk("zero finish", 64'(finish), 64'(1));
        tick();
        chk("zero finish_pulse", 64'(finish), 64'(0));
        chk("zero busy_end", 64'(busy), 64'(0));
        chk("zero ap_start", 64'(start_hi_cnt - sh0), 64'(0));
        chk("zero finish_count", 64'(fin_cnt - fin0), 64'(1));

        // Reset with two transactions inflight.
        ready_delay = 0;
        cur_la = 10;
        cur_lb = 10;
        kern_en = 1'b1;
        cfg_num_txn = 16'd4;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_inflight == 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("midrst reach_inflight", 64'(got), 64'(1));
        tick();
        chk("midrst issued_before", 64'(txn_issued), 64'(2));
        fin0 = fin_cnt;
        reset = 1'b1;
        kern_en = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'(0));
        chk("midrst ap_start", 64'(ap_start), 64'(0));
        chk("midrst ap_continue", 64'(ap_continue), 64'(0));
        chk("midrst txn_issued", 64'(txn_issued), 64'(0));
        chk("midrst txn_done", 64'(txn_done), 64'(0));
        chk("midrst finish", 64'(finish), 64'(0));
        chk("midrst proto_err", 64'(proto_err), 64'(0));
        chk("midrst lat_min", 64'(lat_min), 64'(0));
        chk("midrst lat_max", 64'(lat_max), 64'(0));
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("midrst no_finish", 64'(fin_cnt - fin0), 64'(0));
        chk("midrst idle", 64'(busy), 64'(0));
        chk("midrst txn_issued_after", 64'(txn_issued), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ap_ctrl_sequencer.md
AP_CTRL_SEQUENCER -- requirements
Module: ap_ctrl_sequencer

Interface
REQ-001 SHALL have parameter TXN_W, default 16: width of transaction counts.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 2, legal range 1..8: maximum number of started transactions not yet done.
REQ-003 SHALL have parameter LAT_W, default 32: width of latency values.
REQ-004 SHALL have these ports, one per line:
  clock  in  1  sole clock; all logic on its rising edge.
  reset  in  1  asynchronous, active-high reset.
  cfg_num_txn  in  TXN_W  number of transactions per run; sampled on cmd_start.
  cmd_start  in  1  single-cycle run request; honoured only in IDLE.
  cmd_abort  in  1  level request to stop issuing new transactions.
  busy  out  1  high in every state except IDLE.
  finish  out  1  one-cycle pulse at end of run.
  ap_start  out  1  kernel start.
  ap_ready  in  1  kernel accepted start.
  ap_done  in  1  kernel transaction complete.
  ap_continue  out  1  done acknowledge to kernel.
  txn_issued  out  TXN_W  count of start handshakes in the current run.
  txn_done  out  TXN_W  count of acknowledged dones in the current run.
  proto_err  out  1  sticky protocol-error flag.
  lat_min, lat_max  out  LAT_W  per-transaction latency statistics.

Function
REQ-005 SHALL implement states IDLE, ISSUE, DRAIN, FINISH.
REQ-006 IDLE: cmd_start with cfg_num_txn>0 SHALL latch N, clear txn_issued, txn_done and statistics, and go to ISSUE; with cfg_num_txn==0 it SHALL go directly to FINISH.
REQ-007 ISSUE: ap_start SHALL be high while txn_issued<N and inflight<MAX_INFLIGHT (inflight = txn_issued - txn_done).
REQ-008 A start handshake is ap_start&ap_ready in the same cycle; it SHALL increment txn_issued on that edge.
REQ-009 Once raised, ap_start SHALL stay high until ap_ready; neither inflight limits nor cmd_abort may drop it early.
REQ-010 ISSUE SHALL go to DRAIN when txn_issued reaches N, or on the first cycle with cmd_abort high and no start pending.
REQ-011 ap_continue SHALL be high in ISSUE and DRAIN. ap_done&ap_continue SHALL increment txn_done.
REQ-012 A simultaneous start handshake and done SHALL leave inflight unchanged and update both counters.
REQ-013 DRAIN: ap_start low; when txn_done==txn_issued, go to FINISH.
REQ-014 FINISH: finish=1 for exactly one cycle, then go to IDLE. The counters SHALL hold their values until the next cmd_start.
REQ-015 ap_done while inflight==0, or ap_ready while ap_start is low, SHALL set proto_err. proto_err SHALL be cleared only by reset or an accepted cmd_start. The offending done SHALL not be counted.
REQ-016 Latency SHALL be the cycle count from the start handshake edge to the done edge, saturating at 2^LAT_W-1. Dones SHALL be matched to starts in FIFO order.

Reset
REQ-017 Reset SHALL force IDLE, and SHALL force every output, including lat_min and lat_max, to 0.
REQ-018 A reset in the middle of a run SHALL discard all inflight bookkeeping. No finish pulse SHALL be produced.

Configuration
REQ-019 Macro AP_SEQ_LATENCY_STATS_EN. When defined: a timestamp FIFO and a free-running cycle counter SHALL be instantiated; lat_min SHALL initialise to all-ones at cmd_start and lat_max to 0, and both SHALL be updated on every counted done. When undefined: lat_min and lat_max SHALL be tied to 0, with no FIFO and no counter present.

Structure
REQ-020 Package ap_seq_pkg SHALL hold the state enum, the default values of TXN_W and LAT_W, and the MAX_INFLIGHT upper bound.
REQ-021 Sub-module ap_seq_ts_fifo SHALL be used: depth MAX_INFLIGHT, width LAT_W; push on start handshake, pop on counted done. It SHALL be instantiated only under the macro.

Verification
REQ-022 N=4, kernel with ready on the same cycle and done 3 cycles later -> txn_issued=4, txn_done=4, finish pulses once, and lat_min=lat_max=3 with the macro.
REQ-023 N=5, MAX_INFLIGHT=2, done delayed 10 cycles -> ap_start never high while inflight=2, and inflight never exceeds 2.
REQ-024 ap_ready held low for 6 cycles while cmd_abort is asserted -> ap_start stays high until ready, then DRAIN, and finish arrives with txn_done=txn_issued=1.
REQ-025 cfg_num_txn=0 with cmd_start -> finish is high 2 cycles after cmd_start and ap_start never rises.
REQ-026 Spurious ap_done in IDLE -> proto_err=1 and txn_done stays 0; the next cmd_start clears proto_err.
REQ-027 Reset asserted with 2 transactions inflight -> all outputs are 0 at once, the state is IDLE, and there is no finish pulse.
